pmci_vdm_tx_seq: RTL and testbench
==================================

PMCI_VDM_TX_SEQ -- requirements
Module: pmci_vdm_tx_seq

Interface
REQ-001 SHALL have parameters: FCR_ADDR, default 32'h42000, VDM flow-control register address; TXDR_ADDR, default 32'h42008, VDM TX data register address; MIN_DW, default 4, minimum packet dwords; MAX_DW, default 16, maximum packet dwords; POLL_MAX, default 1023, FCR polls allowed before timeout.
REQ-002 SHALL have ports: clk in 1, the single clock; rst in 1, synchronous active-high reset.
REQ-003 SHALL have requester ports: pkt_valid in 1; pkt_ready out 1; pkt_data in 32; pkt_sop in 1; pkt_eop in 1.
REQ-004 SHALL have CSR master ports: csr_req out 1; csr_wr out 1; csr_addr out 32; csr_wdata out 32; csr_ack in 1, one-cycle completion; csr_rdata in 32, valid with a read csr_ack.
REQ-005 SHALL have status ports: busy out 1; done out 1, pulse; err_len out 1, pulse; err_tmo out 1, pulse; sent_cnt out 16, count of launched packets.

Function
REQ-006 SHALL implement the FSM states IDLE, POLL, DATA, LAUNCH, ABORT and DRAIN.
REQ-007 IDLE: when pkt_valid&pkt_sop, SHALL go to POLL without consuming the word; when pkt_valid&!pkt_sop, SHALL discard the word (pkt_ready=1) and stay in IDLE.
REQ-008 POLL: SHALL issue a read of FCR_ADDR, holding csr_req until csr_ack.
REQ-009 POLL: when csr_rdata[0]=1 (TX buffer empty), SHALL go to DATA; otherwise it SHALL increment poll_cnt and re-issue the read on the next cycle.
REQ-010 POLL: when poll_cnt reaches POLL_MAX with a rejecting ack, SHALL pulse err_tmo for 1 cycle and go to DRAIN.
REQ-011 DATA: pkt_ready SHALL be 1 only when no CSR write is outstanding; each accepted word SHALL produce a write of pkt_data to TXDR_ADDR, with csr_req asserted the cycle after acceptance and held until csr_ack.
REQ-012 DATA: SHALL count accepted words in dw_cnt (8 bit, cleared on entry to POLL).
REQ-013 DATA: an accepted word with pkt_sop=1 after the first word SHALL be a length error.
REQ-014 DATA: when an accepted word makes dw_cnt equal MAX_DW without eop, that SHALL be a length error.
REQ-015 DATA: eop with dw_cnt<MIN_DW (including that word) SHALL be a length error.
REQ-016 DATA: eop with MIN_DW<=dw_cnt<=MAX_DW, after the last write ack, SHALL go to LAUNCH.
REQ-017 On a length error, after any outstanding write ack, the block SHALL pulse err_len and go to ABORT.
REQ-018 LAUNCH: SHALL write FCR_ADDR with wdata = {16'h0, dw_cnt[7:0], 7'h0, 1'b1} (bit0 start, bits[15:8] length); on ack it SHALL pulse done, increment sent_cnt (wraps 16'hFFFF->0) and return to IDLE.
REQ-019 ABORT: SHALL write FCR_ADDR with wdata = 32'h2 (bit1 flush); on ack it SHALL go to IDLE if the erroring word had eop, else to DRAIN.
REQ-020 DRAIN: SHALL hold pkt_ready=1, discard words and issue no CSR access, returning to IDLE the cycle after an accepted eop word.
REQ-021 A word carrying both sop and eop SHALL be a 1-dword packet, treated per REQ-015.
REQ-022 busy SHALL be 1 in every state except IDLE.
REQ-023 csr_addr, csr_wr and csr_wdata SHALL remain stable while csr_req=1.
REQ-024 At most one CSR access SHALL be outstanding at a time.
REQ-025 done, err_len and err_tmo SHALL be mutually exclusive, each 1 cycle wide.
REQ-026 The block SHALL treat a csr_ack arriving while csr_req=0 as ignored.

Reset
REQ-027 While rst=1, the state SHALL be IDLE; csr_req, csr_wr, pkt_ready, busy, done, err_len and err_tmo SHALL be 0; csr_addr, csr_wdata, dw_cnt and poll_cnt SHALL be 0; sent_cnt SHALL be 16'h0.
REQ-028 Reset asserted mid-packet SHALL abandon the transfer with no flush write, and the first cycle after reset SHALL behave as IDLE.

Verification
REQ-029 Send an 8-dword packet with FCR reading 1 on the first poll -> 1 FCR read, 8 TXDR writes in order, FCR write 32'h0000_0801, done pulse, sent_cnt=1.
REQ-030 FCR reads 0 three times then 1 -> 4 FCR reads, then normal transfer; no err_tmo.
REQ-031 FCR always reads 0 with POLL_MAX=3 -> err_tmo after the 3rd rejecting ack, packet drained, no TXDR write, sent_cnt unchanged.
REQ-032 Send a 20-dword packet with MAX_DW=16 -> 16 TXDR writes, err_len, FCR write 32'h2, remaining 4 words drained, no done.
REQ-033 Send a 2-dword packet -> 2 TXDR writes, err_len, FCR write 32'h2, return to IDLE; then a valid 4-dword packet -> FCR write 32'h0000_0401, done.
REQ-034 Assert rst during the 5th TXDR write -> all outputs at reset values next cycle; a subsequent packet completes normally with sent_cnt=1.

Source files
------------

// File: rtl/pmci_vdm_tx_seq.sv
// PMCI VDM transmit sequencer: polls the flow-control register, streams packet
// dwords into the TX data register, then launches or flushes the VDM buffer.
module pmci_vdm_tx_seq #(
  parameter logic [31:0] FCR_ADDR  = 32'h42000,
  parameter logic [31:0] TXDR_ADDR = 32'h42008,
  parameter int unsigned MIN_DW    = 4,
  parameter int unsigned MAX_DW    = 16,
  parameter int unsigned POLL_MAX  = 1023
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        pkt_valid,
  output logic        pkt_ready,
  input  logic [31:0] pkt_data,
  input  logic        pkt_sop,
  input  logic        pkt_eop,
  output logic        csr_req,
  output logic        csr_wr,
  output logic [31:0] csr_addr,
  output logic [31:0] csr_wdata,
  input  logic        csr_ack,
  input  logic [31:0] csr_rdata,
  output logic        busy,
  output logic        done,
  output logic        err_len,
  output logic        err_tmo,
  output logic [15:0] sent_cnt
);

  localparam int PW = (POLL_MAX < 2) ? 1 : $clog2(POLL_MAX + 1);
  localparam logic [PW-1:0] POLL_LIMIT = PW'(POLL_MAX);
  localparam logic [7:0]    MIN_C      = 8'(MIN_DW);
  localparam logic [7:0]    MAX_C      = 8'(MAX_DW);

  typedef enum logic [2:0] {IDLE, POLL, DATA, LAUNCH, ABORT, DRAIN} state_t;
  typedef enum logic [1:0] {PEND_NONE, PEND_LAUNCH, PEND_ERR} pend_t;

  state_t        state_q, state_d;
  pend_t         pend_q, pend_d;
  logic          csr_req_q, csr_req_d;
  logic          csr_wr_q, csr_wr_d;
  logic [31:0]   csr_addr_q, csr_addr_d;
  logic [31:0]   csr_wdata_q, csr_wdata_d;
  logic [7:0]    dw_cnt_q, dw_cnt_d;
  logic [PW-1:0] poll_cnt_q, poll_cnt_d;
  logic [15:0]   sent_cnt_q, sent_cnt_d;
  logic          err_eop_q, err_eop_d;
  logic          done_q, done_d;
  logic          err_len_q, err_len_d;
  logic          err_tmo_q, err_tmo_d;
  logic          ready_c;
  logic          ack_hit;
  logic [7:0]    cnt_inc;
  logic [PW-1:0] poll_inc;
  logic          unused_rdata;

  // Acks are only meaningful against an access we actually have in flight.
  assign ack_hit      = csr_req_q & csr_ack;
  assign cnt_inc      = dw_cnt_q + 8'd1;
  assign poll_inc     = poll_cnt_q + 1'b1;
  assign unused_rdata = ^csr_rdata[31:1];

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= IDLE;
      pend_q      <= PEND_NONE;
      csr_req_q   <= 1'b0;
      csr_wr_q    <= 1'b0;
      csr_addr_q  <= '0;
      csr_wdata_q <= '0;
      dw_cnt_q    <= '0;
      poll_cnt_q  <= '0;
      sent_cnt_q  <= '0;
      err_eop_q   <= 1'b0;
      done_q      <= 1'b0;
      err_len_q   <= 1'b0;
      err_tmo_q   <= 1'b0;
    end else begin
      state_q     <= state_d;
      pend_q      <= pend_d;
      csr_req_q   <= csr_req_d;
      csr_wr_q    <= csr_wr_d;
      csr_addr_q  <= csr_addr_d;
      csr_wdata_q <= csr_wdata_d;
      dw_cnt_q    <= dw_cnt_d;
      poll_cnt_q  <= poll_cnt_d;
      sent_cnt_q  <= sent_cnt_d;
      err_eop_q   <= err_eop_d;
      done_q      <= done_d;
      err_len_q   <= err_len_d;
      err_tmo_q   <= err_tmo_d;
    end
  end

  always_comb begin
    state_d     = state_q;
    pend_d      = pend_q;
    csr_req_d   = csr_req_q;
    csr_wr_d    = csr_wr_q;
    csr_addr_d  = csr_addr_q;
    csr_wdata_d = csr_wdata_q;
    dw_cnt_d    = dw_cnt_q;
    poll_cnt_d  = poll_cnt_q;
    sent_cnt_d  = sent_cnt_q;
    err_eop_d   = err_eop_q;
    done_d      = 1'b0;
    err_len_d   = 1'b0;
    err_tmo_d   = 1'b0;
    ready_c     = 1'b0;

    unique case (state_q)
      IDLE: begin
        // A stray non-sop word is swallowed; an sop word waits for the poll.
        ready_c = pkt_valid & ~pkt_sop;
        if (pkt_valid && pkt_sop) begin
          state_d     = POLL;
          dw_cnt_d    = '0;
          poll_cnt_d  = '0;
          pend_d      = PEND_NONE;
          err_eop_d   = 1'b0;
          csr_req_d   = 1'b1;
          csr_wr_d    = 1'b0;
          csr_addr_d  = FCR_ADDR;
          csr_wdata_d = '0;
        end
      end

      POLL: begin
        if (ack_hit) begin
          poll_cnt_d = poll_inc;
          if (csr_rdata[0]) begin
            state_d   = DATA;
            csr_req_d = 1'b0;
          end else if (poll_inc == POLL_LIMIT) begin
            state_d   = DRAIN;
            csr_req_d = 1'b0;
            err_tmo_d = 1'b1;
          end
        end
      end

      DATA: begin
        ready_c = ~csr_req_q;
        if (pkt_valid && !csr_req_q) begin
          csr_req_d   = 1'b1;
          csr_wr_d    = 1'b1;
          csr_addr_d  = TXDR_ADDR;
          csr_wdata_d = pkt_data;
          dw_cnt_d    = cnt_inc;
          err_eop_d   = pkt_eop;
          if ((pkt_sop && dw_cnt_q != 8'd0) || (pkt_eop && cnt_inc < MIN_C) ||
              (!pkt_eop && cnt_inc == MAX_C)) begin
            pend_d = PEND_ERR;
          end else if (pkt_eop) begin
            pend_d = PEND_LAUNCH;
          end else begin
            pend_d = PEND_NONE;
          end
        end else if (ack_hit) begin
          csr_req_d = 1'b0;
          pend_d    = PEND_NONE;
          // The follow-on FCR write is issued back-to-back with the last data ack.
          if (pend_q == PEND_LAUNCH) begin
            state_d     = LAUNCH;
            csr_req_d   = 1'b1;
            csr_wr_d    = 1'b1;
            csr_addr_d  = FCR_ADDR;
            csr_wdata_d = {16'h0, dw_cnt_q, 7'h0, 1'b1};
          end else if (pend_q == PEND_ERR) begin
            state_d     = ABORT;
            err_len_d   = 1'b1;
            csr_req_d   = 1'b1;
            csr_wr_d    = 1'b1;
            csr_addr_d  = FCR_ADDR;
            csr_wdata_d = 32'h2;
          end
        end
      end

      LAUNCH: begin
        if (ack_hit) begin
          state_d    = IDLE;
          csr_req_d  = 1'b0;
          done_d     = 1'b1;
          sent_cnt_d = sent_cnt_q + 16'd1;
        end
      end

      ABORT: begin
        if (ack_hit) begin
          csr_req_d = 1'b0;
          state_d   = err_eop_q ? IDLE : DRAIN;
        end
      end

      DRAIN: begin
        ready_c = 1'b1;
        if (pkt_valid && pkt_eop) state_d = IDLE;
      end

      default: state_d = IDLE;
    endcase
  end

  assign pkt_ready = ready_c & ~rst;
  assign busy      = (state_q != IDLE) & ~rst;
  assign csr_req   = csr_req_q;
  assign csr_wr    = csr_wr_q;
  assign csr_addr  = csr_addr_q;
  assign csr_wdata = csr_wdata_q;
  assign done      = done_q;
  assign err_len   = err_len_q;
  assign err_tmo   = err_tmo_q;
  assign sent_cnt  = sent_cnt_q;

endmodule

// File: tb/tb_pmci_vdm_tx_seq.sv
// Directed bench for pmci_vdm_tx_seq: a default instance plus a POLL_MAX=3
// instance for the timeout case, sharing one packet driver and CSR responder.
module tb_pmci_vdm_tx_seq;
  localparam logic [31:0] FCR  = 32'h42000;
  localparam logic [31:0] TXDR = 32'h42008;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        sel = 1'b0;
  logic        pkt_valid = 1'b0, pkt_sop = 1'b0, pkt_eop = 1'b0;
  logic [31:0] pkt_data = '0;
  logic        csr_ack_m = 1'b0, stray_ack = 1'b0;
  logic [31:0] csr_rdata = '0;
  logic        ack_all;

  always #5 clk = ~clk;
  assign ack_all = csr_ack_m | stray_ack;

  logic [1:0]  rdy_w, req_w, wr_w, busy_w, done_w, errl_w, errt_w;
  logic [31:0] addr_w [2];
  logic [31:0] wdata_w [2];
  logic [15:0] sent_w [2];

  pmci_vdm_tx_seq u_dut0 (
    .clk(clk), .rst(rst),
    .pkt_valid(pkt_valid & ~sel), .pkt_ready(rdy_w[0]), .pkt_data(pkt_data),
    .pkt_sop(pkt_sop), .pkt_eop(pkt_eop),
    .csr_req(req_w[0]), .csr_wr(wr_w[0]), .csr_addr(addr_w[0]), .csr_wdata(wdata_w[0]),
    .csr_ack(ack_all & ~sel), .csr_rdata(csr_rdata),
    .busy(busy_w[0]), .done(done_w[0]), .err_len(errl_w[0]), .err_tmo(errt_w[0]),
    .sent_cnt(sent_w[0])
  );

  pmci_vdm_tx_seq #(.POLL_MAX(3)) u_dut1 (
    .clk(clk), .rst(rst),
    .pkt_valid(pkt_valid & sel), .pkt_ready(rdy_w[1]), .pkt_data(pkt_data),
    .pkt_sop(pkt_sop), .pkt_eop(pkt_eop),
    .csr_req(req_w[1]), .csr_wr(wr_w[1]), .csr_addr(addr_w[1]), .csr_wdata(wdata_w[1]),
    .csr_ack(ack_all & sel), .csr_rdata(csr_rdata),
    .busy(busy_w[1]), .done(done_w[1]), .err_len(errl_w[1]), .err_tmo(errt_w[1]),
    .sent_cnt(sent_w[1])
  );

  logic        pkt_ready, csr_req, csr_wr, busy, done, err_len, err_tmo;
  logic [31:0] csr_addr, csr_wdata;
  logic [15:0] sent_cnt;
  assign pkt_ready = rdy_w[sel];
  assign csr_req   = req_w[sel];
  assign csr_wr    = wr_w[sel];
  assign csr_addr  = addr_w[sel];
  assign csr_wdata = wdata_w[sel];
  assign busy      = busy_w[sel];
  assign done      = done_w[sel];
  assign err_len   = errl_w[sel];
  assign err_tmo   = errt_w[sel];
  assign sent_cnt  = sent_w[sel];

  // CSR responder configuration (written by the stimulus only)
  int lat = 1;
  int ok_after = 0;
  bit always_zero = 1'b0;
  bit abort_send = 1'b0;

  // Responder / monitor state (written by the responder only)
  int          read_n = 0, wcnt = 0, log_n = 0;
  logic        log_wr   [256];
  logic [31:0] log_addr [256];
  logic [31:0] log_data [256];
  int          done_n = 0, errl_n = 0, errt_n = 0, multi_n = 0, stab_err = 0;
  logic        prev_req = 1'b0, prev_wr = 1'b0;
  logic [31:0] prev_addr = '0, prev_wdata = '0;

  int checks = 0;
  int failures = 0;

  always @(negedge clk) begin
    if (done === 1'b1) done_n++;
    if (err_len === 1'b1) errl_n++;
    if (err_tmo === 1'b1) errt_n++;
    if ((int'(done === 1'b1) + int'(err_len === 1'b1) + int'(err_tmo === 1'b1)) > 1) multi_n++;
    if (!rst && prev_req === 1'b1 && csr_ack_m === 1'b0 && csr_req === 1'b1 &&
        (csr_wr !== prev_wr || csr_addr !== prev_addr || csr_wdata !== prev_wdata)) stab_err++;
    prev_req   = csr_req;
    prev_wr    = csr_wr;
    prev_addr  = csr_addr;
    prev_wdata = csr_wdata;
    if (rst) begin
      csr_ack_m = 1'b0;
      wcnt = 0;
    end else if (csr_ack_m) begin
      csr_ack_m = 1'b0;
      wcnt = 0;
    end else if (csr_req === 1'b1) begin
      if (wcnt >= lat) begin
        csr_ack_m = 1'b1;
        wcnt = 0;
        if (csr_wr) begin
          csr_rdata = '0;
        end else begin
          csr_rdata = {31'h0, (!always_zero && read_n >= ok_after)};
          read_n++;
        end
        if (log_n < 256) begin
          log_wr[log_n]   = csr_wr;
          log_addr[log_n] = csr_addr;
          log_data[log_n] = csr_wdata;
          log_n++;
        end
      end else begin
        wcnt++;
      end
    end
  end

  task automatic send_pkt(input int n, input logic [31:0] base, input bit first_sop, output bit ok);
    int wait_c;
    ok = 1'b1;
    for (int i = 0; i < n && ok && !abort_send; i++) begin
      @(negedge clk);
      pkt_valid = 1'b1;
      pkt_data  = base + 32'(i);
      pkt_sop   = (i == 0) && first_sop;
      pkt_eop   = (i == n - 1);
      #1;
      wait_c = 0;
      while (pkt_ready !== 1'b1 && wait_c < 400 && !abort_send) begin
        @(negedge clk);
        #1;
        wait_c++;
      end
      if (pkt_ready !== 1'b1) ok = 1'b0;
    end
    @(negedge clk);
    pkt_valid = 1'b0;
    pkt_sop   = 1'b0;
    pkt_eop   = 1'b0;
  endtask

  task automatic wait_idle(output bit ok);
    int c;
    ok = 1'b0;
    c = 0;
    while (!ok && c < 500) begin
      @(negedge clk);
      #1;
      if (busy === 1'b0 && csr_req === 1'b0) ok = 1'b1;
      c++;
    end
  endtask

  task automatic test_reset;
    rst = 1'b1;
    pkt_valid = 1'b1;
    pkt_sop = 1'b1;
    repeat (3) @(negedge clk);
    #1;
    checks++;
    if ({pkt_ready, busy, csr_req, csr_wr, done, err_len, err_tmo} !== 7'b0)
      $display("FAIL reset_ctrl got=%b exp=0000000", {pkt_ready, busy, csr_req, csr_wr, done, err_len, err_tmo});
    checks++;
    if (csr_addr !== 32'h0 || csr_wdata !== 32'h0)
      $display("FAIL reset_addr_data got=%h/%h exp=0/0", csr_addr, csr_wdata);
    checks++;
    if (sent_w[0] !== 16'h0 || sent_w[1] !== 16'h0)
      $display("FAIL reset_sent_cnt got=%h/%h exp=0/0", sent_w[0], sent_w[1]);
    if ((pkt_ready | busy | csr_req | csr_wr | done | err_len | err_tmo) !== 1'b0 ||
        csr_addr !== 32'h0 || csr_wdata !== 32'h0 || sent_w[0] !== 16'h0 || sent_w[1] !== 16'h0)
      failures++;
    $display("test_reset: checked reset outputs");
    pkt_valid = 1'b0;
    pkt_sop = 1'b0;
    rst = 1'b0;
    @(negedge clk);
  endtask

  task automatic test_basic;
    bit ok1, ok2;
    int l0, d0, e0, t0;
    sel = 1'b0; lat = 1; always_zero = 1'b0; ok_after = read_n;
    l0 = log_n; d0 = done_n; e0 = errl_n; t0 = errt_n;
    send_pkt(8, 32'hA000_0000, 1'b1, ok1);
    wait_idle(ok2);
    checks++;
    if (!(ok1 && ok2)) begin failures++; $display("FAIL basic_handshake got=%0d%0d exp=11", ok1, ok2); end
    checks++;
    if (log_n - l0 !== 10) begin failures++; $display("FAIL basic_access_count got=%0d exp=10", log_n - l0); end
    checks++;
    if (log_wr[l0] !== 1'b0 || log_addr[l0] !== FCR) begin
      failures++; $display("FAIL basic_fcr_read got=wr%b@%h exp=wr0@%h", log_wr[l0], log_addr[l0], FCR);
    end
    for (int k = 0; k < 8; k++) begin
      checks++;
      if (log_wr[l0+1+k] !== 1'b1 || log_addr[l0+1+k] !== TXDR || log_data[l0+1+k] !== 32'hA000_0000 + 32'(k)) begin
        failures++;
        $display("FAIL basic_txdr_%0d got=wr%b@%h=%h exp=wr1@%h=%h", k, log_wr[l0+1+k], log_addr[l0+1+k],
                 log_data[l0+1+k], TXDR, 32'hA000_0000 + 32'(k));
      end
    end
    checks++;
    if (log_wr[l0+9] !== 1'b1 || log_addr[l0+9] !== FCR || log_data[l0+9] !== 32'h0000_0801) begin
      failures++; $display("FAIL basic_launch got=wr%b@%h=%h exp=wr1@%h=00000801", log_wr[l0+9], log_addr[l0+9], log_data[l0+9], FCR);
    end
    checks++;
    if (done_n - d0 !== 1 || errl_n - e0 !== 0 || errt_n - t0 !== 0) begin
      failures++; $display("FAIL basic_pulses got=d%0d l%0d t%0d exp=d1 l0 t0", done_n - d0, errl_n - e0, errt_n - t0);
    end
    checks++;
    if (sent_cnt !== 16'd1) begin failures++; $display("FAIL basic_sent_cnt got=%0d exp=1", sent_cnt); end
    $display("test_basic: 8-dword packet, %0d accesses", log_n - l0);
  endtask

  task automatic test_idle_discard;
    bit ok1;
    int l0;
    sel = 1'b0;
    l0 = log_n;
    send_pkt(3, 32'hE000_0000, 1'b0, ok1);
    #1;
    checks++;
    if (!ok1 || busy !== 1'b0) begin failures++; $display("FAIL discard_accept got=ok%0d busy%b exp=ok1 busy0", ok1, busy); end
    @(negedge clk);
    stray_ack = 1'b1;
    @(negedge clk);
    stray_ack = 1'b0;
    repeat (2) @(negedge clk);
    #1;
    checks++;
    if (log_n - l0 !== 0 || csr_req !== 1'b0 || busy !== 1'b0 || sent_cnt !== 16'd1) begin
      failures++; $display("FAIL discard_stray_ack got=acc%0d req%b busy%b sent%0d exp=acc0 req0 busy0 sent1",
                           log_n - l0, csr_req, busy, sent_cnt);
    end
    $display("test_idle_discard: 3 non-sop words and a stray ack");
  endtask

  task automatic test_poll_retry;
    bit ok1, ok2;
    int l0, d0, t0;
    sel = 1'b0; lat = 0; ok_after = read_n + 3;
    l0 = log_n; d0 = done_n; t0 = errt_n;
    send_pkt(4, 32'hB000_0000, 1'b1, ok1);
    wait_idle(ok2);
    checks++;
    if (log_n - l0 !== 9) begin failures++; $display("FAIL retry_access_count got=%0d exp=9", log_n - l0); end
    for (int k = 0; k < 4; k++) begin
      checks++;
      if (log_wr[l0+k] !== 1'b0 || log_addr[l0+k] !== FCR) begin
        failures++; $display("FAIL retry_read_%0d got=wr%b@%h exp=wr0@%h", k, log_wr[l0+k], log_addr[l0+k], FCR);
      end
    end
    checks++;
    if (log_wr[l0+4] !== 1'b1 || log_addr[l0+4] !== TXDR || log_data[l0+4] !== 32'hB000_0000) begin
      failures++; $display("FAIL retry_first_txdr got=%h@%h exp=b0000000@%h", log_data[l0+4], log_addr[l0+4], TXDR);
    end
    checks++;
    if (log_data[l0+8] !== 32'h0000_0401 || log_addr[l0+8] !== FCR) begin
      failures++; $display("FAIL retry_launch got=%h@%h exp=00000401@%h", log_data[l0+8], log_addr[l0+8], FCR);
    end
    checks++;
    if (!(ok1 && ok2) || done_n - d0 !== 1 || errt_n - t0 !== 0 || sent_cnt !== 16'd2) begin
      failures++; $display("FAIL retry_status got=ok%0d%0d d%0d t%0d sent%0d exp=ok11 d1 t0 sent2",
                           ok1, ok2, done_n - d0, errt_n - t0, sent_cnt);
    end
    $display("test_poll_retry: 3 rejected polls then transfer");
  endtask

  task automatic test_timeout;
    bit ok1, ok2;
    int l0, d0, e0, t0;
    @(negedge clk);
    sel = 1'b1; lat = 1; always_zero = 1'b1;
    l0 = log_n; d0 = done_n; e0 = errl_n; t0 = errt_n;
    send_pkt(5, 32'hC000_0000, 1'b1, ok1);
    wait_idle(ok2);
    checks++;
    if (log_n - l0 !== 3) begin failures++; $display("FAIL tmo_access_count got=%0d exp=3", log_n - l0); end
    for (int k = 0; k < 3; k++) begin
      checks++;
      if (log_wr[l0+k] !== 1'b0 || log_addr[l0+k] !== FCR) begin
        failures++; $display("FAIL tmo_read_%0d got=wr%b@%h exp=wr0@%h", k, log_wr[l0+k], log_addr[l0+k], FCR);
      end
    end
    checks++;
    if (errt_n - t0 !== 1 || done_n - d0 !== 0 || errl_n - e0 !== 0) begin
      failures++; $display("FAIL tmo_pulses got=d%0d l%0d t%0d exp=d0 l0 t1", done_n - d0, errl_n - e0, errt_n - t0);
    end
    checks++;
    if (!(ok1 && ok2) || sent_cnt !== 16'd0) begin
      failures++; $display("FAIL tmo_drain got=ok%0d%0d sent%0d exp=ok11 sent0", ok1, ok2, sent_cnt);
    end
    $display("test_timeout: POLL_MAX=3 timeout and drain");
    always_zero = 1'b0;
    @(negedge clk);
    sel = 1'b0;
  endtask

  task automatic test_overlong;
    bit ok1, ok2;
    int l0, d0, e0;
    sel = 1'b0; lat = 1; ok_after = read_n;
    l0 = log_n; d0 = done_n; e0 = errl_n;
    send_pkt(20, 32'hD000_0000, 1'b1, ok1);
    wait_idle(ok2);
    checks++;
    if (log_n - l0 !== 18) begin failures++; $display("FAIL long_access_count got=%0d exp=18", log_n - l0); end
    for (int k = 0; k < 16; k++) begin
      checks++;
      if (log_wr[l0+1+k] !== 1'b1 || log_addr[l0+1+k] !== TXDR || log_data[l0+1+k] !== 32'hD000_0000 + 32'(k)) begin
        failures++; $display("FAIL long_txdr_%0d got=%h@%h exp=%h@%h", k, log_data[l0+1+k], log_addr[l0+1+k],
                             32'hD000_0000 + 32'(k), TXDR);
      end
    end
    checks++;
    if (log_wr[l0+17] !== 1'b1 || log_addr[l0+17] !== FCR || log_data[l0+17] !== 32'h2) begin
      failures++; $display("FAIL long_flush got=%h@%h exp=00000002@%h", log_data[l0+17], log_addr[l0+17], FCR);
    end
    checks++;
    if (!(ok1 && ok2) || errl_n - e0 !== 1 || done_n - d0 !== 0 || sent_cnt !== 16'd2) begin
      failures++; $display("FAIL long_status got=ok%0d%0d l%0d d%0d sent%0d exp=ok11 l1 d0 sent2",
                           ok1, ok2, errl_n - e0, done_n - d0, sent_cnt);
    end
    $display("test_overlong: 20-dword packet truncated at 16");
  endtask

  task automatic test_short_then_ok;
    bit ok1, ok2;
    int l0, d0, e0;
    sel = 1'b0; ok_after = read_n;
    l0 = log_n; d0 = done_n; e0 = errl_n;
    send_pkt(2, 32'h5000_0000, 1'b1, ok1);
    wait_idle(ok2);
    checks++;
    if (log_n - l0 !== 4 || log_data[l0+2] !== 32'h5000_0001 || log_data[l0+3] !== 32'h2 || log_addr[l0+3] !== FCR) begin
      failures++; $display("FAIL short_accesses got=n%0d last=%h@%h exp=n4 last=00000002@%h",
                           log_n - l0, log_data[l0+3], log_addr[l0+3], FCR);
    end
    checks++;
    if (!(ok1 && ok2) || errl_n - e0 !== 1 || done_n - d0 !== 0) begin
      failures++; $display("FAIL short_status got=ok%0d%0d l%0d d%0d exp=ok11 l1 d0", ok1, ok2, errl_n - e0, done_n - d0);
    end
    $display("test_short: 2-dword packet rejected");
    l0 = log_n; d0 = done_n;
    send_pkt(4, 32'h6000_0000, 1'b1, ok1);
    wait_idle(ok2);
    checks++;
    if (log_n - l0 !== 6 || log_data[l0+5] !== 32'h0000_0401 || log_addr[l0+5] !== FCR) begin
      failures++; $display("FAIL after_short_launch got=n%0d last=%h exp=n6 last=00000401", log_n - l0, log_data[l0+5]);
    end
    checks++;
    if (done_n - d0 !== 1 || sent_cnt !== 16'd3) begin
      failures++; $display("FAIL after_short_status got=d%0d sent%0d exp=d1 sent3", done_n - d0, sent_cnt);
    end
    $display("test_short_then_ok: 4-dword packet launched");
  endtask

  task automatic test_single_word;
    bit ok1, ok2;
    int l0, e0;
    sel = 1'b0; ok_after = read_n;
    l0 = log_n; e0 = errl_n;
    send_pkt(1, 32'h7000_0000, 1'b1, ok1);
    wait_idle(ok2);
    checks++;
    if (log_n - l0 !== 3 || log_data[l0+1] !== 32'h7000_0000 || log_addr[l0+1] !== TXDR ||
        log_data[l0+2] !== 32'h2 || errl_n - e0 !== 1 || sent_cnt !== 16'd3) begin
      failures++; $display("FAIL single_word got=n%0d d1=%h d2=%h l%0d sent%0d exp=n3 d1=70000000 d2=00000002 l1 sent3",
                           log_n - l0, log_data[l0+1], log_data[l0+2], errl_n - e0, sent_cnt);
    end
    $display("test_single_word: sop+eop dword rejected");
  endtask

  task automatic test_reset_mid;
    bit ok1, ok2, found;
    int l0, d0;
    sel = 1'b0; lat = 2; ok_after = read_n; abort_send = 1'b0;
    found = 1'b0;
    fork
      send_pkt(8, 32'hF000_0000, 1'b1, ok1);
      begin
        for (int c = 0; c < 400 && !found; c++) begin
          @(negedge clk);
          #2;
          if (csr_req === 1'b1 && csr_wr === 1'b1 && csr_addr === TXDR && csr_wdata === 32'hF000_0004) found = 1'b1;
        end
        rst = 1'b1;
        abort_send = 1'b1;
        @(negedge clk);
        #2;
        checks++;
        if (!found) begin failures++; $display("FAIL midrst_5th_write got=absent exp=seen"); end
        checks++;
        if ({csr_req, csr_wr, pkt_ready, busy, done, err_len, err_tmo} !== 7'b0 ||
            csr_addr !== 32'h0 || csr_wdata !== 32'h0 || sent_cnt !== 16'h0) begin
          failures++; $display("FAIL midrst_outputs got=%b %h %h sent%0d exp=0000000 0 0 sent0",
                               {csr_req, csr_wr, pkt_ready, busy, done, err_len, err_tmo}, csr_addr, csr_wdata, sent_cnt);
        end
      end
    join
    rst = 1'b0;
    abort_send = 1'b0;
    lat = 1;
    @(negedge clk);
    l0 = log_n; d0 = done_n; ok_after = read_n;
    send_pkt(4, 32'h9000_0000, 1'b1, ok1);
    wait_idle(ok2);
    checks++;
    if (log_n - l0 !== 6 || log_data[l0+1] !== 32'h9000_0000 || log_data[l0+5] !== 32'h0000_0401) begin
      failures++; $display("FAIL midrst_recover got=n%0d d1=%h last=%h exp=n6 d1=90000000 last=00000401",
                           log_n - l0, log_data[l0+1], log_data[l0+5]);
    end
    checks++;
    if (!(ok1 && ok2) || done_n - d0 !== 1 || sent_cnt !== 16'd1) begin
      failures++; $display("FAIL midrst_status got=ok%0d%0d d%0d sent%0d exp=ok11 d1 sent1", ok1, ok2, done_n - d0, sent_cnt);
    end
    $display("test_reset_mid: reset during 5th TXDR write, then recovery");
  endtask

  task automatic test_protocol;
    checks++;
    if (stab_err !== 0) begin failures++; $display("FAIL csr_stability got=%0d exp=0", stab_err); end
    checks++;
    if (multi_n !== 0) begin failures++; $display("FAIL pulse_exclusive got=%0d exp=0", multi_n); end
    $display("test_protocol: stability and pulse exclusivity");
  endtask

  initial begin
    test_reset();
    test_basic();
    test_idle_discard();
    test_poll_retry();
    test_timeout();
    test_overlong();
    test_short_then_ok();
    test_single_word();
    test_reset_mid();
    test_protocol();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
